// File: rtl/mem_rd_arbiter.sv
// Two-master read arbiter in front of one AXI-lite AR/R slave port, one read in flight.
// Build option ARB_RR_EN: round-robin between simultaneous requesters instead of fixed m1 priority.
module mem_rd_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RESP_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] m0_araddr,
   input  logic [ADDR_W-1:0] m1_araddr,
   input  logic              m0_arvalid,
   input  logic              m1_arvalid,
   output logic              m0_arready,
   output logic              m1_arready,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [RESP_W-1:0] m0_rresp,
   output logic [RESP_W-1:0] m1_rresp,
   output logic              m0_rvalid,
   output logic              m1_rvalid,
   input  logic              m0_rready,
   input  logic              m1_rready,
   output logic [ADDR_W-1:0] s_araddr,
   output logic              s_arvalid,
   input  logic              s_arready,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic [RESP_W-1:0] s_rresp,
   input  logic              s_rvalid,
   output logic              s_rready,
   output logic [1:0]        grant,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ADDR, RD} state_t;

   state_t            state, state_nx;
   logic [1:0]        grant_q, grant_nx;
   logic [ADDR_W-1:0] addr_q, addr_nx;
   logic              pick_m1;
   logic              rd_ready;

`ifdef ARB_RR_EN
   // last_grant: 0 = m0 was granted last, 1 = m1
   logic last_grant, last_grant_nx;

   always_comb pick_m1 = m1_arvalid & (~m0_arvalid | ~last_grant);
`else
   always_comb pick_m1 = m1_arvalid;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         grant_q <= '0;
         addr_q  <= '0;
`ifdef ARB_RR_EN
         last_grant <= 1'b0;
`endif
      end else begin
         state   <= state_nx;
         grant_q <= grant_nx;
         addr_q  <= addr_nx;
`ifdef ARB_RR_EN
         last_grant <= last_grant_nx;
`endif
      end
   end

   always_comb begin
      state_nx   = state;
      grant_nx   = grant_q;
      addr_nx    = addr_q;
`ifdef ARB_RR_EN
      last_grant_nx = last_grant;
`endif
      s_arvalid  = 1'b0;
      m0_arready = 1'b0;
      m1_arready = 1'b0;
      m0_rvalid  = 1'b0;
      m1_rvalid  = 1'b0;
      rd_ready   = 1'b0;
      case (state)
         IDLE: begin
            if (m0_arvalid | m1_arvalid) begin
               grant_nx = pick_m1 ? 2'b10 : 2'b01;
               addr_nx  = pick_m1 ? m1_araddr : m0_araddr;
`ifdef ARB_RR_EN
               last_grant_nx = pick_m1;
`endif
               state_nx = ADDR;
            end
         end
         ADDR: begin
            s_arvalid  = 1'b1;
            m0_arready = grant_q[0] & s_arready;
            m1_arready = grant_q[1] & s_arready;
            if (s_arready) state_nx = RD;
         end
         RD: begin
            m0_rvalid = grant_q[0] & s_rvalid;
            m1_rvalid = grant_q[1] & s_rvalid;
            rd_ready  = (grant_q[0] & m0_rready) | (grant_q[1] & m1_rready);
            if (s_rvalid & rd_ready) begin
               grant_nx = '0;
               state_nx = IDLE;
            end
         end
         default: begin
            grant_nx = '0;
            state_nx = IDLE;
         end
      endcase
   end

   // Data and response are broadcast; each master qualifies them with its own rvalid
   assign m0_rdata = s_rdata;
   assign m1_rdata = s_rdata;
   assign m0_rresp = s_rresp;
   assign m1_rresp = s_rresp;
   assign s_rready = rd_ready;
   assign s_araddr = addr_q;
   assign grant    = grant_q;
   assign busy     = (state != IDLE);

endmodule

// File: doc/mem_rd_arbiter.md
Name: mem_rd_arbiter

Overview:
- Shares a single memory read port (AXI-lite AR/R channels) between the instruction fetch unit (master 0) and the load/store unit (master 1).
- Handles one outstanding read at a time. Grants a requester, forwards its address, and steers the read data and response back to the granted master only.
- Sits between the fetch/LSU read ports and the memory slave. LSU writes bypass this block.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
RESP_W, 2, rresp width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
m0_araddr, m1_araddr  in  ADDR_W  read address from IFU (m0) / LSU (m1)
m0_arvalid, m1_arvalid  in  1  read request valid
m0_arready, m1_arready  out  1  read request accepted
m0_rdata, m1_rdata  out  DATA_W  read data (both driven from s_rdata)
m0_rresp, m1_rresp  out  RESP_W  read response (both driven from s_rresp)
m0_rvalid, m1_rvalid  out  1  read data valid, granted master only
m0_rready, m1_rready  in  1  master ready for read data
s_araddr  out  ADDR_W  address to memory slave
s_arvalid  out  1  address valid to slave
s_arready  in  1  slave accepts address
s_rdata  in  DATA_W  slave read data
s_rresp  in  RESP_W  slave response
s_rvalid  in  1  slave read data valid
s_rready  out  1  ready to slave, equals granted master's rready in RD
grant  out  2  one-hot current owner; 00 when idle
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: clock is clk; reset is rst, synchronous and active-high. Outputs after reset:
  - state=IDLE, grant=00, busy=0
  - s_arvalid=0, s_araddr=0, s_rready=0
  - m*_arready=0, m*_rvalid=0
- Reset mid-transaction: the arbiter returns to IDLE at the next edge and abandons the transaction. The slave shares rst.
- State machine: IDLE -> ADDR -> RD -> IDLE.
- IDLE:
  - If any m*_arvalid is high, choose a winner. Default policy: m1 (LSU) has fixed priority.
  - Register grant and latch the winner's araddr into s_araddr. Go to ADDR.
  - No request: stay in IDLE.
- ADDR:
  - s_arvalid=1.
  - The granted master's arready is combinationally equal to s_arready. The other master's arready is 0.
  - On s_arvalid & s_arready: go to RD.
- RD:
  - Granted m*_rvalid = s_rvalid. Other m*_rvalid = 0.
  - s_rready = granted m*_rready.
  - On s_rvalid & s_rready: go to IDLE and clear grant.
- Latency:
  - A request seen in cycle N drives s_arvalid in cycle N+1.
  - With a zero-wait slave: arready handshake in N+1, rvalid earliest in N+2.
  - There is one IDLE bubble between back-to-back transactions. Minimum 3 cycles per read.
- Masters must hold arvalid and araddr until arready. Dropping a request mid-grant is unsupported. The arbiter completes the latched transaction anyway.
- A request from the non-granted master waits; it is evaluated only in IDLE.
- If both requests arrive in the same cycle, one is granted. The loser's arvalid remains pending and is granted in the next IDLE.
- m*_rdata and m*_rresp are broadcast. Consumers qualify them with their own rvalid.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined:
  - Round-robin. A 1-bit last_grant register (reset 0 = m0) is updated on every grant.
  - On a simultaneous request, the master not granted last wins.
  - A single requester is always granted.
- Undefined: fixed priority, m1 over m0. last_grant is not implemented.

Test Plan:
1. Single IFU read:
   - Stimulus: m0_arvalid=1, m0_araddr=0x8000_0000; slave arready=1, returns rdata=0x0000_0093 one cycle later.
   - Required: s_araddr=0x8000_0000; m0_rvalid pulses with m0_rdata=0x93; m1_rvalid stays 0; grant returns to 00.
2. Simultaneous requests, fixed priority:
   - Stimulus: m0 at 0x100 and m1 at 0x200 in the same cycle.
   - Required: m1 is served first (s_araddr=0x200), then m0 (0x100). Each master sees exactly one rvalid.
3. ARB_RR_EN:
   - Stimulus: both masters request continuously for 4 transactions.
   - Required: grant sequence m1, m0, m1, m0 (last_grant reset=m0).
4. Slave backpressure:
   - Stimulus: s_arready low for 3 cycles, then s_rvalid held while m1_rready is low for 2 cycles.
   - Required: s_arvalid and s_araddr stay stable; m1_arready is asserted only in the handshake cycle; the data beat completes only when m1_rready=1.
5. Reset in RD:
   - Stimulus: assert rst for 1 cycle while in RD with s_rvalid=1 and m0_rready=0.
   - Required: the next cycle shows busy=0, grant=00, and all valids and readys 0; a fresh request after reset is served normally.
6. Back-to-back from one master:
   - Stimulus: m1_arvalid re-asserted immediately after its r handshake.
   - Required: exactly one IDLE cycle between transactions; 3 cycles per read with a zero-wait slave.
